// File: rtl/add_subt_pkg.sv
// Shared encodings for the sliced add/subtract engine: FSM states and operation codes.
package add_subt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_subt_slice.sv
// CHUNK-bit combinational ripple slice; the top reuses one instance for every slice position.
module add_subt_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum     = total_s[CHUNK-1:0];
  assign cout    = total_s[CHUNK];

endmodule

// File: rtl/fixed_add_subt_unit.sv
// Multi-cycle two's-complement add/subtract, one CHUNK-bit slice per clock, with ready/ack handshake.
// Build option: define ADD_SUBT_SAT_EN to clamp overflowing results to the signed extreme.
module fixed_add_subt_unit
  import add_subt_pkg::*;
#(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         op_add_subt,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  output logic         ready_add_subt,
  output logic         busy_add_subt,
  output logic [W-1:0] add_subt_result,
  output logic         overflow_flag
);

  localparam int N_SLICE = W / CHUNK;
  localparam int CNT_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICE - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic [W-1:0]     x_r;
  logic [W-1:0]     y_r;
  logic [W-1:0]     sum_r;
  logic [W-1:0]     result_r;
  logic             ovf_r;
  logic             ready_r;
  logic             busy_r;

  logic [CHUNK-1:0] slice_a_s;
  logic [CHUNK-1:0] slice_b_s;
  logic [CHUNK-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             ovf_s;

  assign slice_a_s = x_r[cnt_r*CHUNK +: CHUNK];
  assign slice_b_s = y_r[cnt_r*CHUNK +: CHUNK];

  add_subt_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Y is stored already inverted for subtraction, so its MSB is the effective sign.
  assign ovf_s = (x_r[W-1] == y_r[W-1]) && (sum_r[W-1] != x_r[W-1]);

`ifdef ADD_SUBT_SAT_EN
  logic [W-1:0] sat_s;
  assign sat_s = x_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif

  // Handshake FSM with slice sequencing, operand/sum capture and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      carry_r  <= 1'b0;
      x_r      <= '0;
      y_r      <= '0;
      sum_r    <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      unique case (state_r)
        IDLE: begin
          if (beg_add_subt) begin
            x_r     <= Data_X;
            y_r     <= Data_Y ^ {W{op_add_subt == OP_SUB}};
            carry_r <= (op_add_subt == OP_SUB);
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= CALC;
          end
        end
        CALC: begin
          sum_r[cnt_r*CHUNK +: CHUNK] <= slice_sum_s;
          carry_r <= slice_cout_s;
          if (cnt_r == LAST_CNT) begin
            state_r <= FINAL;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        FINAL: begin
          ovf_r    <= ovf_s;
`ifdef ADD_SUBT_SAT_EN
          result_r <= ovf_s ? sat_s : sum_r;
`else
          result_r <= sum_r;
`endif
          busy_r   <= 1'b0;
          ready_r  <= 1'b1;
          state_r  <= DONE;
        end
        DONE: begin
          if (ack_add_subt) begin
            ready_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ready_add_subt  = ready_r;
  assign busy_add_subt   = busy_r;
  assign add_subt_result = result_r;
  assign overflow_flag   = ovf_r;

endmodule

// File: tb/tb_fixed_add_subt_unit.sv
// Directed self-checking bench for fixed_add_subt_unit (W=32, CHUNK=8), both saturation builds.
module tb_fixed_add_subt_unit;

  logic        clk;
  logic        reset;
  logic        beg_add_subt;
  logic        ack_add_subt;
  logic        op_add_subt;
  logic [31:0] Data_X;
  logic [31:0] Data_Y;
  logic        ready_add_subt;
  logic        busy_add_subt;
  logic [31:0] add_subt_result;
  logic        overflow_flag;

  int n_total;
  int n_pass;

  fixed_add_subt_unit #(.W(32), .CHUNK(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .beg_add_subt    (beg_add_subt),
    .ack_add_subt    (ack_add_subt),
    .op_add_subt     (op_add_subt),
    .Data_X          (Data_X),
    .Data_Y          (Data_Y),
    .ready_add_subt  (ready_add_subt),
    .busy_add_subt   (busy_add_subt),
    .add_subt_result (add_subt_result),
    .overflow_flag   (overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present operands with beg for exactly one rising edge; returns at the following falling edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic op);
    @(negedge clk);
    Data_X       = x;
    Data_Y       = y;
    op_add_subt  = op;
    beg_add_subt = 1'b1;
    @(negedge clk);
    beg_add_subt = 1'b0;
  endtask

  // Count rising edges until ready rises (bounded) and compare with the expected count.
  task automatic wait_ready(input string tag, input int exp_cycles);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ready_add_subt === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) cyc = 99;
    check(tag, 32'(cyc), 32'(exp_cycles));
  endtask

  // Acknowledge in DONE (optionally with a simultaneous beg) and confirm ready drops on that edge.
  task automatic ack_op(input string tag, input logic with_beg);
    @(negedge clk);
    ack_add_subt = 1'b1;
    beg_add_subt = with_beg;
    if (with_beg) begin
      Data_X = 32'h0000_0001;
      Data_Y = 32'h0000_0001;
      op_add_subt = 1'b0;
    end
    @(posedge clk);
    #1;
    check(tag, {31'd0, ready_add_subt}, 32'd0);
    @(negedge clk);
    ack_add_subt = 1'b0;
    beg_add_subt = 1'b0;
  endtask

  logic [31:0] exp_r3;
  logic [31:0] exp_r4;
  logic        stray_ready;

  initial begin
    n_total = 0;
    n_pass  = 0;
`ifdef ADD_SUBT_SAT_EN
    exp_r3 = 32'h7FFF_FFFF;
    exp_r4 = 32'h8000_0000;
`else
    exp_r3 = 32'h8000_0000;
    exp_r4 = 32'h7FFF_FFFF;
`endif
    reset        = 1'b1;
    beg_add_subt = 1'b0;
    ack_add_subt = 1'b0;
    op_add_subt  = 1'b0;
    Data_X       = 32'd0;
    Data_Y       = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready",  {31'd0, ready_add_subt}, 32'd0);
    check("rst_busy",   {31'd0, busy_add_subt},  32'd0);
    check("rst_result", add_subt_result,         32'd0);
    check("rst_ovf",    {31'd0, overflow_flag},  32'd0);
    reset = 1'b0;

    // 1: carry ripples across slice boundaries
    start_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
    check("t1_busy", {31'd0, busy_add_subt}, 32'd1);
    wait_ready("t1_latency", 5);
    check("t1_result", add_subt_result, 32'h0100_0000);
    check("t1_ovf", {31'd0, overflow_flag}, 32'd0);
    check("t1_busy_done", {31'd0, busy_add_subt}, 32'd0);
    // beg together with ack in DONE: ack wins, beg is not taken
    ack_op("t1_ack", 1'b1);
    check("t1_beg_ignored", {31'd0, busy_add_subt}, 32'd0);

    // 2: subtraction with negative result, held without ack
    start_op(32'd3, 32'd5, 1'b1);
    wait_ready("t2_latency", 5);
    check("t2_result", add_subt_result, 32'hFFFF_FFFE);
    check("t2_ovf", {31'd0, overflow_flag}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold_ready", {31'd0, ready_add_subt}, 32'd1);
      check("t2_hold_result", add_subt_result, 32'hFFFF_FFFE);
    end
    ack_op("t2_ack", 1'b0);
    check("t2_idle_result", add_subt_result, 32'hFFFF_FFFE);

    // 3: positive overflow on add
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_ready("t3_latency", 5);
    check("t3_result", add_subt_result, exp_r3);
    check("t3_ovf", {31'd0, overflow_flag}, 32'd1);
    ack_op("t3_ack", 1'b0);

    // 4: negative overflow on subtract
    start_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    wait_ready("t4_latency", 5);
    check("t4_result", add_subt_result, exp_r4);
    check("t4_ovf", {31'd0, overflow_flag}, 32'd1);
    ack_op("t4_ack", 1'b0);

    // 5: beg and ack pulsed during CALC are ignored
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    beg_add_subt = 1'b1;
    ack_add_subt = 1'b1;
    Data_X       = 32'hFFFF_FFFF;
    Data_Y       = 32'hFFFF_FFFF;
    op_add_subt  = 1'b1;
    @(negedge clk);
    beg_add_subt = 1'b0;
    ack_add_subt = 1'b0;
    check("t5_busy", {31'd0, busy_add_subt}, 32'd1);
    wait_ready("t5_latency", 4);
    check("t5_result", add_subt_result, 32'h2345_6789);
    check("t5_ovf", {31'd0, overflow_flag}, 32'd0);
    ack_op("t5_ack", 1'b0);
    stray_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready_add_subt !== 1'b0 || busy_add_subt !== 1'b0) stray_ready = 1'b1;
    end
    check("t5_no_second_op", {31'd0, stray_ready}, 32'd0);

    // 6: reset during the second CALC cycle aborts everything
    start_op(32'h0000_0055, 32'h0000_0022, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_rst_busy",   {31'd0, busy_add_subt},  32'd0);
    check("t6_rst_ready",  {31'd0, ready_add_subt}, 32'd0);
    check("t6_rst_result", add_subt_result,         32'd0);
    check("t6_rst_ovf",    {31'd0, overflow_flag},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    stray_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready_add_subt !== 1'b0) stray_ready = 1'b1;
    end
    check("t6_no_ready_pulse", {31'd0, stray_ready}, 32'd0);
    start_op(32'd10, 32'd4, 1'b1);
    wait_ready("t6_latency", 5);
    check("t6_result", add_subt_result, 32'd6);
    check("t6_ovf", {31'd0, overflow_flag}, 32'd0);
    ack_op("t6_ack", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
